// File: rtl/echo_request_input_pipes_if.sv
// Host-to-hardware request bundle for the Echo portal: message-size query, two word-push
// channels, the per-method valid/ready outputs and the dropped-write count.
interface echo_request_input_pipes_if #(parameter int ERR_CNT_W = 16);
    logic [15:0]          portalIfc_messageSize_size_methodNumber;
    logic [15:0]          portalIfc_messageSize_size;
    logic                 RDY_portalIfc_messageSize_size;
    logic [31:0]          portalIfc_requests_0_enq_v;
    logic                 EN_portalIfc_requests_0_enq;
    logic                 RDY_portalIfc_requests_0_enq;
    logic                 portalIfc_requests_0_notFull;
    logic [31:0]          portalIfc_requests_1_enq_v;
    logic                 EN_portalIfc_requests_1_enq;
    logic                 RDY_portalIfc_requests_1_enq;
    logic                 portalIfc_requests_1_notFull;
    logic                 methods_say_valid;
    logic [31:0]          methods_say_v;
    logic                 methods_say_ready;
    logic                 methods_say2_valid;
    logic [31:0]          methods_say2_a;
    logic [31:0]          methods_say2_b;
    logic                 methods_say2_ready;
    logic [ERR_CNT_W-1:0] portalIfc_err_count;

    modport slave (
        input  portalIfc_messageSize_size_methodNumber,
        output portalIfc_messageSize_size, RDY_portalIfc_messageSize_size,
        input  portalIfc_requests_0_enq_v, EN_portalIfc_requests_0_enq,
        output RDY_portalIfc_requests_0_enq, portalIfc_requests_0_notFull,
        input  portalIfc_requests_1_enq_v, EN_portalIfc_requests_1_enq,
        output RDY_portalIfc_requests_1_enq, portalIfc_requests_1_notFull,
        output methods_say_valid, methods_say_v,
        input  methods_say_ready,
        output methods_say2_valid, methods_say2_a, methods_say2_b,
        input  methods_say2_ready,
        output portalIfc_err_count
    );

    modport master (
        output portalIfc_messageSize_size_methodNumber,
        input  portalIfc_messageSize_size, RDY_portalIfc_messageSize_size,
        output portalIfc_requests_0_enq_v, EN_portalIfc_requests_0_enq,
        input  RDY_portalIfc_requests_0_enq, portalIfc_requests_0_notFull,
        output portalIfc_requests_1_enq_v, EN_portalIfc_requests_1_enq,
        input  RDY_portalIfc_requests_1_enq, portalIfc_requests_1_notFull,
        input  methods_say_valid, methods_say_v,
        output methods_say_ready,
        input  methods_say2_valid, methods_say2_a, methods_say2_b,
        output methods_say2_ready,
        input  portalIfc_err_count
    );
endinterface

// File: rtl/echo_request_input_pipes.sv
// Echo request input pipes: collects pushed 32-bit words into say(v) / say2(a,b) messages held
// in one-entry buffers. Define ECHO_REQ_ERRCNT_EN to count words pushed while a channel is full.
module echo_request_input_pipes #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    echo_request_input_pipes_if.slave   pif
);
    logic        full0_q, full0_d;
    logic [31:0] say_v_q, say_v_d;
    logic        full1_q, full1_d;
    logic        idx_q, idx_d;
    logic [31:0] say2_a_q, say2_a_d;
    logic [31:0] say2_b_q, say2_b_d;
    logic        acc0, acc1;

    assign acc0 = pif.EN_portalIfc_requests_0_enq & ~full0_q;
    assign acc1 = pif.EN_portalIfc_requests_1_enq & ~full1_q;

    always_comb begin
        full0_d  = full0_q;
        say_v_d  = say_v_q;
        full1_d  = full1_q;
        idx_d    = idx_q;
        say2_a_d = say2_a_q;
        say2_b_d = say2_b_q;
        // Consume and accept are exclusive per channel: accept needs !full, consume needs full.
        if (full0_q && pif.methods_say_ready) full0_d = 1'b0;
        if (acc0) begin
            say_v_d = pif.portalIfc_requests_0_enq_v;
            full0_d = 1'b1;
        end
        if (full1_q && pif.methods_say2_ready) full1_d = 1'b0;
        if (acc1) begin
            if (!idx_q) begin
                say2_a_d = pif.portalIfc_requests_1_enq_v;
                idx_d    = 1'b1;
            end else begin
                say2_b_d = pif.portalIfc_requests_1_enq_v;
                idx_d    = 1'b0;
                full1_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            full0_q  <= 1'b0;
            say_v_q  <= '0;
            full1_q  <= 1'b0;
            idx_q    <= 1'b0;
            say2_a_q <= '0;
            say2_b_q <= '0;
        end else begin
            full0_q  <= full0_d;
            say_v_q  <= say_v_d;
            full1_q  <= full1_d;
            idx_q    <= idx_d;
            say2_a_q <= say2_a_d;
            say2_b_q <= say2_b_d;
        end
    end

    always_comb begin
        case (pif.portalIfc_messageSize_size_methodNumber)
            16'd0:   pif.portalIfc_messageSize_size = 16'd32;
            16'd1:   pif.portalIfc_messageSize_size = 16'd64;
            default: pif.portalIfc_messageSize_size = 16'd0;
        endcase
    end

    assign pif.RDY_portalIfc_messageSize_size = 1'b1;
    assign pif.RDY_portalIfc_requests_0_enq   = ~full0_q;
    assign pif.portalIfc_requests_0_notFull   = ~full0_q;
    assign pif.RDY_portalIfc_requests_1_enq   = ~full1_q;
    assign pif.portalIfc_requests_1_notFull   = ~full1_q;
    assign pif.methods_say_valid              = full0_q;
    assign pif.methods_say_v                  = say_v_q;
    assign pif.methods_say2_valid             = full1_q;
    assign pif.methods_say2_a                 = say2_a_q;
    assign pif.methods_say2_b                 = say2_b_q;

`ifdef ECHO_REQ_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [1:0]           drop_inc;
    logic [ERR_CNT_W:0]   err_sum;

    assign drop_inc = {1'b0, pif.EN_portalIfc_requests_0_enq & full0_q}
                    + {1'b0, pif.EN_portalIfc_requests_1_enq & full1_q};
    assign err_sum  = {1'b0, err_cnt_q} + {{(ERR_CNT_W-1){1'b0}}, drop_inc};

    // Carry out of the extended sum means the count would wrap; pin it at all ones.
    always_comb begin
        err_cnt_d = err_sum[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : err_sum[ERR_CNT_W-1:0];
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign pif.portalIfc_err_count = err_cnt_q;
`else
    assign pif.portalIfc_err_count = {ERR_CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_echo_request_input_pipes.sv
// Scoreboard bench for echo_request_input_pipes: stimulus pushes expected messages, a negedge
// monitor pops and compares whenever a handshake completes.
module tb_echo_request_input_pipes;
    localparam int ERR_CNT_W = 16;
`ifdef ECHO_REQ_ERRCNT_EN
    localparam int EXP_DROPS = 3;
`else
    localparam int EXP_DROPS = 0;
`endif

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   nchecks = 0;
    int   nerrors = 0;

    logic [31:0] say_q[$];
    logic [63:0] say2_q[$];

    echo_request_input_pipes_if #(.ERR_CNT_W(ERR_CNT_W)) pif ();

    echo_request_input_pipes #(.ERR_CNT_W(ERR_CNT_W)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .pif  (pif.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic enq(input int ch, input logic [31:0] v);
        if (ch == 0) begin
            pif.portalIfc_requests_0_enq_v  = v;
            pif.EN_portalIfc_requests_0_enq = 1'b1;
        end else begin
            pif.portalIfc_requests_1_enq_v  = v;
            pif.EN_portalIfc_requests_1_enq = 1'b1;
        end
        tick();
        pif.EN_portalIfc_requests_0_enq = 1'b0;
        pif.EN_portalIfc_requests_1_enq = 1'b0;
    endtask

    // Monitor: a handshake seen at negedge completes at the following posedge.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (pif.methods_say_valid && pif.methods_say_ready) begin
                nchecks++;
                if (say_q.size() == 0) begin
                    nerrors++;
                    $display("FAIL say_unexpected: got %0h expected none", pif.methods_say_v);
                end else begin
                    logic [31:0] e;
                    e = say_q.pop_front();
                    if (pif.methods_say_v !== e) begin
                        nerrors++;
                        $display("FAIL say_data: got %0h expected %0h", pif.methods_say_v, e);
                    end
                end
            end
            if (pif.methods_say2_valid && pif.methods_say2_ready) begin
                nchecks++;
                if (say2_q.size() == 0) begin
                    nerrors++;
                    $display("FAIL say2_unexpected: got %0h_%0h expected none",
                             pif.methods_say2_a, pif.methods_say2_b);
                end else begin
                    logic [63:0] e;
                    e = say2_q.pop_front();
                    if ({pif.methods_say2_a, pif.methods_say2_b} !== e) begin
                        nerrors++;
                        $display("FAIL say2_data: got %0h_%0h expected %0h",
                                 pif.methods_say2_a, pif.methods_say2_b, e);
                    end
                end
            end
        end
    end

    initial begin
        pif.portalIfc_messageSize_size_methodNumber = 16'd0;
        pif.portalIfc_requests_0_enq_v  = '0;
        pif.EN_portalIfc_requests_0_enq = 1'b0;
        pif.portalIfc_requests_1_enq_v  = '0;
        pif.EN_portalIfc_requests_1_enq = 1'b0;
        pif.methods_say_ready  = 1'b0;
        pif.methods_say2_ready = 1'b0;
        RST_N = 1'b0;
        tick(); tick();
        RST_N = 1'b1;
        tick();

        // 1: reset state and message sizes
        chk("rst_say_valid",  pif.methods_say_valid, 0);
        chk("rst_say2_valid", pif.methods_say2_valid, 0);
        chk("rst_rdy0",       pif.RDY_portalIfc_requests_0_enq, 1);
        chk("rst_rdy1",       pif.RDY_portalIfc_requests_1_enq, 1);
        chk("rst_notfull1",   pif.portalIfc_requests_1_notFull, 1);
        chk("rst_say_v",      pif.methods_say_v, 0);
        chk("rst_say2_ab",    {pif.methods_say2_a, pif.methods_say2_b}, 0);
        chk("rst_err",        pif.portalIfc_err_count, 0);
        chk("size_rdy",       pif.RDY_portalIfc_messageSize_size, 1);
        pif.portalIfc_messageSize_size_methodNumber = 16'd0; #1;
        chk("size0", pif.portalIfc_messageSize_size, 32);
        pif.portalIfc_messageSize_size_methodNumber = 16'd1; #1;
        chk("size1", pif.portalIfc_messageSize_size, 64);
        pif.portalIfc_messageSize_size_methodNumber = 16'd7; #1;
        chk("size7", pif.portalIfc_messageSize_size, 0);

        // 2: say with backpressure, then consume
        enq(0, 32'hDEADBEEF);
        chk("t2_valid",    pif.methods_say_valid, 1);
        chk("t2_v",        pif.methods_say_v, 64'hDEADBEEF);
        chk("t2_rdy0",     pif.RDY_portalIfc_requests_0_enq, 0);
        chk("t2_notfull0", pif.portalIfc_requests_0_notFull, 0);
        say_q.push_back(32'hDEADBEEF);
        tick();
        chk("t2_hold", pif.methods_say_valid, 1);
        pif.methods_say_ready = 1'b1;
        tick();
        pif.methods_say_ready = 1'b0;
        chk("t2_cleared", pif.methods_say_valid, 0);
        chk("t2_rdy_back", pif.RDY_portalIfc_requests_0_enq, 1);
        chk("t2_v_hold", pif.methods_say_v, 64'hDEADBEEF);

        // 3: say2 with a gap between words
        enq(1, 32'h1);
        chk("t3_after_a", pif.methods_say2_valid, 0);
        repeat (3) tick();
        chk("t3_gap", pif.methods_say2_valid, 0);
        enq(1, 32'h2);
        chk("t3_valid", pif.methods_say2_valid, 1);
        chk("t3_ab", {pif.methods_say2_a, pif.methods_say2_b}, {32'h1, 32'h2});
        chk("t3_rdy1", pif.RDY_portalIfc_requests_1_enq, 0);
        say2_q.push_back({32'h1, 32'h2});
        pif.methods_say2_ready = 1'b1;
        tick();
        pif.methods_say2_ready = 1'b0;
        chk("t3_cleared", pif.methods_say2_valid, 0);

        // 4: reset mid-message discards the partial say2
        enq(1, 32'h5);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        chk("t4_rst_valid", pif.methods_say2_valid, 0);
        chk("t4_rst_a", pif.methods_say2_a, 0);
        enq(1, 32'h7);
        chk("t4_one_word", pif.methods_say2_valid, 0);
        enq(1, 32'h8);
        chk("t4_valid", pif.methods_say2_valid, 1);
        chk("t4_ab", {pif.methods_say2_a, pif.methods_say2_b}, {32'h7, 32'h8});
        say2_q.push_back({32'h7, 32'h8});
        pif.methods_say2_ready = 1'b1;
        tick();
        pif.methods_say2_ready = 1'b0;

        // 5: pushes into a full channel are dropped
        enq(0, 32'h11);
        pif.portalIfc_requests_0_enq_v  = 32'h55;
        pif.EN_portalIfc_requests_0_enq = 1'b1;
        repeat (3) tick();
        pif.EN_portalIfc_requests_0_enq = 1'b0;
        chk("t5_valid", pif.methods_say_valid, 1);
        chk("t5_v", pif.methods_say_v, 32'h11);
        chk("t5_err", pif.portalIfc_err_count, EXP_DROPS);
        say_q.push_back(32'h11);
        pif.methods_say_ready = 1'b1;
        tick();
        pif.methods_say_ready = 1'b0;
        repeat (2) tick();
        chk("t5_err_hold", pif.portalIfc_err_count, EXP_DROPS);

        // 6: both channels at once, ready held high
        say_q.push_back(32'hA1);
        say2_q.push_back({32'hB1, 32'hB2});
        pif.methods_say_ready  = 1'b1;
        pif.methods_say2_ready = 1'b1;
        pif.portalIfc_requests_0_enq_v  = 32'hA1;
        pif.EN_portalIfc_requests_0_enq = 1'b1;
        pif.portalIfc_requests_1_enq_v  = 32'hB1;
        pif.EN_portalIfc_requests_1_enq = 1'b1;
        tick();
        pif.EN_portalIfc_requests_0_enq = 1'b0;
        pif.portalIfc_requests_1_enq_v  = 32'hB2;
        chk("t6_say_valid", pif.methods_say_valid, 1);
        chk("t6_say2_wait", pif.methods_say2_valid, 0);
        tick();
        pif.EN_portalIfc_requests_1_enq = 1'b0;
        chk("t6_say2_valid", pif.methods_say2_valid, 1);
        chk("t6_say_done", pif.methods_say_valid, 0);
        repeat (4) tick();
        pif.methods_say_ready  = 1'b0;
        pif.methods_say2_ready = 1'b0;
        chk("t6_say2_done", pif.methods_say2_valid, 0);
        chk("t6_err", pif.portalIfc_err_count, EXP_DROPS);

        chk("say_q_drained",  say_q.size(), 0);
        chk("say2_q_drained", say2_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
